// File: rtl/ffe_serial_param.sv
// Serial FIR equaliser: one shared MAC walks TAPS taps per sample, coefficients double-buffered.
// Latency: out_valid rises TAPS+1 cycles after input accept; one sample per TAPS+2 cycles at best.
// Backpressure: in_ready low while busy; output held stable until out_ready. Saturation with FFE_SAT_EN.
module ffe_serial_param #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 12,
    parameter int FRAC_W = 6,
    parameter int TAPS   = 4,
    localparam int AW    = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q      [TAPS];
    logic signed [DATA_W-1:0]  x_d      [TAPS];
    logic signed [COEF_W-1:0]  shadow_q [TAPS];
    logic signed [COEF_W-1:0]  shadow_d [TAPS];
    logic signed [COEF_W-1:0]  active_q [TAPS];
    logic signed [COEF_W-1:0]  active_d [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [AW-1:0]             k_q, k_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;

    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [DATA_W-1:0]         result;

    always_comb begin
        prod    = x_q[k_q] * active_q[k_q];
        acc_sum = acc_q + {{AW{prod[PW-1]}}, prod};
    end

    // Scale back by FRAC_W with floor rounding, then fit into DATA_W.
`ifdef FFE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] acc_shr;

    always_comb begin
        acc_shr = acc_sum >>> FRAC_W;
        if (acc_shr > SAT_MAX) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_shr < SAT_MIN) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = acc_shr[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        result = acc_sum[FRAC_W +: DATA_W];
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_MAC;
            S_MAC:   if (k_q == K_LAST) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d        = x_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        acc_d      = acc_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        if (state_q == S_IDLE && in_valid) begin
            x_d[0] = in_data;
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
            // Copy takes the shadow bank as it stood before any write this cycle.
            active_d = shadow_q;
            acc_d    = '0;
            k_d      = '0;
        end
        if (state_q == S_MAC) begin
            acc_d = acc_sum;
            k_d   = k_q + AW'(1);
            if (k_q == K_LAST) begin
                out_data_d = result;
            end
        end
        for (int i = 0; i < TAPS; i++) begin
            if (coef_we && coef_addr == AW'(i)) begin
                shadow_d[i] = coef_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            out_data_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]      <= '0;
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            x_q        <= x_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_ffe_serial_param.sv
// Bench for ffe_serial_param: directed plan scenarios plus random traffic against a sample-level FIR model.
module tb_ffe_serial_param;

    localparam int DATA_W = 12;
    localparam int COEF_W = 12;
    localparam int FRAC_W = 6;
    localparam int TAPS   = 4;
    localparam int AW     = $clog2(TAPS);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    always #5 clk = ~clk;

    ffe_serial_param #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .TAPS(TAPS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sample history, shadow coefficients, and a phase/countdown view of timing.
    int                m_hist   [TAPS];
    int                m_shadow [TAPS];
    int                m_phase;
    int                m_cnt;
    logic [DATA_W-1:0] m_exp;
    bit                m_hs;
    logic [DATA_W-1:0] m_got;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_hist[i]   = 0;
            m_shadow[i] = 0;
        end
        m_phase = 0;
        m_cnt   = 0;
        m_hs    = 1'b0;
        m_exp   = '0;
    endtask

    task automatic model_accept(input int sample, output logic [DATA_W-1:0] res);
        longint sum;
        longint sh;
`ifdef FFE_SAT_EN
        longint maxv;
`endif
        for (int i = TAPS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = sample;
        sum = 0;
        for (int i = 0; i < TAPS; i++) sum += longint'(m_hist[i]) * longint'(m_shadow[i]);
        sh = sum >>> FRAC_W;
`ifdef FFE_SAT_EN
        maxv = (longint'(1) << (DATA_W-1)) - 1;
        if (sh > maxv) sh = maxv;
        if (sh < -maxv - 1) sh = -maxv - 1;
`endif
        res = sh[DATA_W-1:0];
    endtask

    task automatic step(input bit iv, input logic [DATA_W-1:0] id, input bit we,
                        input logic [AW-1:0] wa, input logic [COEF_W-1:0] wd, input bit ordy);
        logic [DATA_W-1:0] r;
        @(negedge clk);
        check_val("in_ready", 32'(in_ready), 32'(m_phase == 0));
        check_val("out_valid", 32'(out_valid), 32'(m_phase == 2));
        check_val("busy", 32'(busy), 32'(m_phase != 0));
        if (m_phase == 2) check_val("out_data", 32'(out_data), 32'(m_exp));
        in_valid   = iv;
        in_data    = id;
        coef_we    = we;
        coef_addr  = wa;
        coef_wdata = wd;
        out_ready  = ordy;
        m_hs = 1'b0;
        case (m_phase)
            0: if (iv) begin
                model_accept(int'($signed(id)), r);
                m_exp   = r;
                m_phase = 1;
                m_cnt   = TAPS;
            end
            1: begin
                m_cnt--;
                if (m_cnt == 0) m_phase = 2;
            end
            default: if (ordy) begin
                m_hs    = 1'b1;
                m_got   = out_data;
                m_phase = 0;
            end
        endcase
        if (we) m_shadow[wa] = int'($signed(wd));
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [COEF_W-1:0] v);
        step(1'b0, '0, 1'b1, a, v, 1'b1);
    endtask

    // Feed one sample; optional coefficient write wcyc cycles after accept (-1: none).
    task automatic run_sample(input logic [DATA_W-1:0] id, input int wcyc, input logic [AW-1:0] wa,
                              input logic [COEF_W-1:0] wd, output logic [DATA_W-1:0] got);
        bit seen = 1'b0;
        got = '0;
        step(1'b1, id, wcyc == 0, wa, wd, 1'b1);
        for (int i = 1; i <= TAPS + 4; i++) begin
            step(1'b0, '0, wcyc == i, wa, wd, 1'b1);
            if (m_hs) begin
                seen = 1'b1;
                got  = m_got;
                break;
            end
        end
        if (!seen) check_val("out_timeout", 32'(0), 32'(1));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'(0));
        check_val("rst_out_data", 32'(out_data), 32'(0));
        check_val("rst_in_ready", 32'(in_ready), 32'(1));
        check_val("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] got;
        model_clear();

        // Impulse response through all taps.
        apply_reset();
        write_coef(0, 12'h020);
        write_coef(1, 12'hFF0);
        write_coef(2, 12'h00A);
        write_coef(3, 12'hFFC);
        run_sample(12'h040, -1, '0, '0, got); check_val("imp0", 32'(got), 32'h020);
        run_sample(12'h000, -1, '0, '0, got); check_val("imp1", 32'(got), 32'hFF0);
        run_sample(12'h000, -1, '0, '0, got); check_val("imp2", 32'(got), 32'h00A);
        run_sample(12'h000, -1, '0, '0, got); check_val("imp3", 32'(got), 32'hFFC);

        // Overflow of the output range.
        apply_reset();
        write_coef(0, 12'h7FF);
        run_sample(12'h7FF, -1, '0, '0, got);
`ifdef FFE_SAT_EN
        check_val("ovf_sat", 32'(got), 32'h7FF);
`else
        check_val("ovf_wrap", 32'(got), 32'hFC0);
`endif

        // Double-buffered coefficients: writes during MAC or at accept land on the next sample.
        apply_reset();
        write_coef(0, 12'h020);
        write_coef(1, 12'h020);
        run_sample(12'h040, 2, 0, 12'h040, got);  check_val("dbuf_mac", 32'(got), 32'h020);
        run_sample(12'h040, -1, '0, '0, got);     check_val("dbuf_next", 32'(got), 32'h060);
        run_sample(12'h040, 0, 0, 12'h010, got);  check_val("dbuf_same", 32'(got), 32'h060);
        run_sample(12'h040, -1, '0, '0, got);     check_val("dbuf_after", 32'(got), 32'h030);

        // Backpressure in OUT with stray in_valid pulses.
        apply_reset();
        write_coef(0, 12'h020);
        step(1'b1, 12'h040, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < TAPS + 5; i++) step(1'($urandom), DATA_W'($urandom), 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        check_val("bp_hs", 32'(m_hs), 32'(1));
        check_val("bp_data", 32'(m_got), 32'h020);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);

        // Reset in the middle of MAC.
        apply_reset();
        write_coef(0, 12'h020);
        write_coef(2, 12'h013);
        run_sample(12'h040, -1, '0, '0, got); check_val("pre_rst", 32'(got), 32'h020);
        step(1'b1, 12'h040, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        check_val("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check_val("mid_rst_out_data", 32'(out_data), 32'(0));
        check_val("mid_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        run_sample(12'h040, -1, '0, '0, got); check_val("post_rst", 32'(got), 32'h000);

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < TAPS; i++) write_coef(AW'(i), COEF_W'($urandom));
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 1) == 1, DATA_W'($urandom), $urandom_range(0, 4) == 0,
                 AW'($urandom), COEF_W'($urandom), $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < TAPS + 4; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
